// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline-hazard definitions: Tuse/Tnew encodings and default HI/LO latencies.
package hazard_ctrl_pkg;

  localparam int TW_DEF       = 2;
  localparam int TNEW_ALU     = 1;
  localparam int TNEW_LOAD    = 2;
  localparam int TUSE_BRANCH  = 0;
  localparam int TUSE_ALU     = 1;
  localparam int TUSE_STORE   = 2;
  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_ctr.sv
// HI/LO busy down-counter: loads the mult or div latency on issue, then counts to zero.
module md_busy_ctr
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic is_div,
  output logic busy
);

  localparam int MW = $clog2(max_int(MULT_LAT, DIV_LAT) + 1);

  logic [MW-1:0] cnt_q;
  logic [MW-1:0] cnt_d;

  // next count: load on issue, otherwise count down and hold at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = is_div ? MW'(DIV_LAT) : MW'(MULT_LAT);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - MW'(1);
    end else begin
      cnt_d = '0;
    end
  end

  // counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage stall generator: Tuse/Tnew scoreboard over E/M write tags plus HI/LO busy tracking.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int RAW      = 5,
  parameter int TW       = TW_DEF,
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int CW       = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [RAW-1:0] rs_D,
  input  logic [RAW-1:0] rt_D,
  input  logic           rs_use_D,
  input  logic           rt_use_D,
  input  logic [TW-1:0]  rs_tuse_D,
  input  logic [TW-1:0]  rt_tuse_D,
  input  logic           we_D,
  input  logic [RAW-1:0] a3_D,
  input  logic [TW-1:0]  tnew_D,
  input  logic           mult_D,
  input  logic           div_D,
  input  logic           md_use_D,
  output logic           stall,
  output logic [RAW-1:0] a3_E,
  output logic [TW-1:0]  tnew_E,
  output logic [RAW-1:0] a3_M,
  output logic [TW-1:0]  tnew_M,
  output logic           md_busy,
  output logic [CW-1:0]  stall_cnt
);

  logic [RAW-1:0] a3_e_q, a3_e_d, a3_m_q, a3_m_d;
  logic [TW-1:0]  tnew_e_q, tnew_e_d, tnew_m_q, tnew_m_d;
  logic [CW-1:0]  stall_cnt_q, stall_cnt_d;
  logic           rs_haz_s, rt_haz_s, md_haz_s, md_busy_s, md_load_s;

  // The youngest (E) producer wins; an older M tag for the same register is stale.
  function automatic logic src_hazard(
    input logic           use_s,
    input logic [RAW-1:0] src,
    input logic [TW-1:0]  tuse,
    input logic [RAW-1:0] a3_e,
    input logic [TW-1:0]  tnew_e,
    input logic [RAW-1:0] a3_m,
    input logic [TW-1:0]  tnew_m
  );
    logic haz;
    if (!use_s || (src == '0)) begin
      haz = 1'b0;
    end else if (a3_e == src) begin
      haz = (tnew_e > tuse);
    end else begin
      haz = (a3_m == src) && (tnew_m > tuse);
    end
    return haz;
  endfunction

  // stall decision from the current D inputs and the shadow tags
  always_comb begin
    rs_haz_s  = src_hazard(rs_use_D, rs_D, rs_tuse_D, a3_e_q, tnew_e_q, a3_m_q, tnew_m_q);
    rt_haz_s  = src_hazard(rt_use_D, rt_D, rt_tuse_D, a3_e_q, tnew_e_q, a3_m_q, tnew_m_q);
    md_haz_s  = md_busy_s && (md_use_D || mult_D || div_D);
    stall     = rs_haz_s || rt_haz_s || md_haz_s;
    md_load_s = (mult_D || div_D) && !stall;
  end

  // next shadow tags and saturating stall counter
  always_comb begin
    a3_e_d   = '0;
    tnew_e_d = '0;
    if (!stall && we_D && (a3_D != '0)) begin
      a3_e_d   = a3_D;
      tnew_e_d = tnew_D;
    end else begin
      a3_e_d   = '0;
      tnew_e_d = '0;
    end
    a3_m_d   = a3_e_q;
    tnew_m_d = (tnew_e_q != '0) ? (tnew_e_q - TW'(1)) : '0;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CW'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // pipeline tag and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a3_e_q      <= '0;
      tnew_e_q    <= '0;
      a3_m_q      <= '0;
      tnew_m_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      a3_e_q      <= a3_e_d;
      tnew_e_q    <= tnew_e_d;
      a3_m_q      <= a3_m_d;
      tnew_m_q    <= tnew_m_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  md_busy_ctr #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_md_busy_ctr (
    .clk    (clk),
    .reset  (reset),
    .load   (md_load_s),
    .is_div (div_D),
    .busy   (md_busy_s)
  );

  assign a3_E      = a3_e_q;
  assign tnew_E    = tnew_e_q;
  assign a3_M      = a3_m_q;
  assign tnew_M    = tnew_m_q;
  assign md_busy   = md_busy_s;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed pipeline scenarios plus random D streams against an issue-history model.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int RAW = 5;
  localparam int TW  = 2;
  localparam int ML  = 5;
  localparam int DL  = 10;
  localparam int CW  = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           reset;
  logic [RAW-1:0] rs_D, rt_D, a3_D;
  logic           rs_use_D, rt_use_D, we_D, mult_D, div_D, md_use_D;
  logic [TW-1:0]  rs_tuse_D, rt_tuse_D, tnew_D;
  logic           stall, md_busy;
  logic [RAW-1:0] a3_E, a3_M;
  logic [TW-1:0]  tnew_E, tnew_M;
  logic [CW-1:0]  stall_cnt;

  hazard_ctrl #(
    .RAW(RAW), .TW(TW), .MULT_LAT(ML), .DIV_LAT(DL), .CW(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .rs_D(rs_D), .rt_D(rt_D), .rs_use_D(rs_use_D), .rt_use_D(rt_use_D),
    .rs_tuse_D(rs_tuse_D), .rt_tuse_D(rt_tuse_D),
    .we_D(we_D), .a3_D(a3_D), .tnew_D(tnew_D),
    .mult_D(mult_D), .div_D(div_D), .md_use_D(md_use_D),
    .stall(stall), .a3_E(a3_E), .tnew_E(tnew_E), .a3_M(a3_M), .tnew_M(tnew_M),
    .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: h_*[0] is the instruction issued one edge ago, h_*[1] two edges ago.
  int h_reg[2];
  int h_tnew[2];
  int m_cyc  = 0;
  int m_done = 0;
  int m_cnt  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sat0(input int v);
    return (v > 0) ? v : 0;
  endfunction

  function automatic bit m_src(input bit u, input int r, input int tuse);
    if (!u || r == 0) return 1'b0;
    for (int k = 0; k < 2; k++)
      if (h_reg[k] == r) return (sat0(h_tnew[k] - k) > tuse);
    return 1'b0;
  endfunction

  function automatic bit m_stall();
    bit mb;
    mb = (m_cyc < m_done);
    return m_src(rs_use_D, int'(rs_D), int'(rs_tuse_D)) |
           m_src(rt_use_D, int'(rt_D), int'(rt_tuse_D)) |
           (mb && (md_use_D || mult_D || div_D));
  endfunction

  task automatic m_edge(input bit s);
    if (s && m_cnt < CNT_MAX) m_cnt++;
    if (!s && (mult_D || div_D)) m_done = m_cyc + 1 + (div_D ? DL : ML);
    h_reg[1]  = h_reg[0];
    h_tnew[1] = h_tnew[0];
    if (s || !we_D || a3_D == '0) begin
      h_reg[0] = 0; h_tnew[0] = 0;
    end else begin
      h_reg[0] = int'(a3_D); h_tnew[0] = int'(tnew_D);
    end
    m_cyc++;
  endtask

  task automatic m_reset();
    h_reg[0] = 0; h_reg[1] = 0; h_tnew[0] = 0; h_tnew[1] = 0;
    m_done = 0; m_cnt = 0;
  endtask

  task automatic d_clear();
    rs_D = '0; rt_D = '0; a3_D = '0; rs_use_D = 1'b0; rt_use_D = 1'b0; we_D = 1'b0;
    rs_tuse_D = '0; rt_tuse_D = '0; tnew_D = '0; mult_D = 1'b0; div_D = 1'b0; md_use_D = 1'b0;
  endtask

  task automatic d_set(input int a3, input int tn, input int rs, input int rt, input int tuse,
                       input bit mu, input bit dv, input bit md);
    we_D = 1'b1; a3_D = RAW'(a3); tnew_D = TW'(tn);
    rs_D = RAW'(rs); rt_D = RAW'(rt); rs_use_D = 1'b1; rt_use_D = 1'b1;
    rs_tuse_D = TW'(tuse); rt_tuse_D = TW'(tuse);
    mult_D = mu; div_D = dv; md_use_D = md;
  endtask

  // One clock: check stall before the edge, advance the model, check registered state after it.
  task automatic cycle(input string tag, input int want);
    bit es;
    #1;
    es = m_stall();
    chk({tag, "_stall"}, stall, es);
    if (want >= 0) chk({tag, "_stall_dir"}, stall, want);
    @(posedge clk);
    m_edge(es);
    #1;
    chk({tag, "_a3E"}, a3_E, h_reg[0]);
    chk({tag, "_tnewE"}, tnew_E, h_tnew[0]);
    chk({tag, "_a3M"}, a3_M, h_reg[1]);
    chk({tag, "_tnewM"}, tnew_M, sat0(h_tnew[1] - 1));
    chk({tag, "_mdbusy"}, md_busy, (m_cyc < m_done));
    chk({tag, "_cnt"}, stall_cnt, m_cnt);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    m_reset();
    #1;
    chk({tag, "_rst_a3E"}, a3_E, 0);
    chk({tag, "_rst_tnewE"}, tnew_E, 0);
    chk({tag, "_rst_a3M"}, a3_M, 0);
    chk({tag, "_rst_tnewM"}, tnew_M, 0);
    chk({tag, "_rst_mdbusy"}, md_busy, 0);
    chk({tag, "_rst_cnt"}, stall_cnt, 0);
    chk({tag, "_rst_stall"}, stall, m_stall());
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    d_clear();
    d_set(3, 0, 3, 3, 0, 1'b0, 1'b0, 1'b1);
    do_reset("init");
    d_clear();

    // load-use: lw $8 then addu $9,$8,$8
    d_set(8, TNEW_LOAD, 0, 0, TUSE_ALU, 1'b0, 1'b0, 1'b0);
    cycle("lu_lw", 0);
    d_set(9, TNEW_ALU, 8, 8, TUSE_ALU, 1'b0, 1'b0, 1'b0);
    cycle("lu_use1", 1);
    cycle("lu_use2", 0);
    chk("lu_cnt", stall_cnt, 1);

    // addu $8 then beq $8,$0; then beq $0 with empty E
    do_reset("br");
    d_set(8, TNEW_ALU, 1, 2, TUSE_ALU, 1'b0, 1'b0, 1'b0);
    cycle("br_addu", 0);
    d_set(0, 0, 8, 0, TUSE_BRANCH, 1'b0, 1'b0, 1'b0);
    cycle("br_beq1", 1);
    cycle("br_beq2", 0);
    d_clear();
    cycle("br_nop", 0);
    d_set(0, 0, 0, 0, TUSE_BRANCH, 1'b0, 1'b0, 1'b0);
    cycle("br_beq0", 0);

    // mult then mflo, then div then mflo
    do_reset("md");
    d_set(0, 0, 1, 2, TUSE_ALU, 1'b1, 1'b0, 1'b0);
    cycle("md_mult", 0);
    d_set(4, TNEW_ALU, 0, 0, TUSE_ALU, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < ML; i++) cycle("md_mflo_m", 1);
    cycle("md_mflo_m_go", 0);
    chk("md_mult_idle", md_busy, 0);
    d_set(0, 0, 1, 2, TUSE_ALU, 1'b0, 1'b1, 1'b0);
    cycle("md_div", 0);
    d_set(4, TNEW_ALU, 0, 0, TUSE_ALU, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < DL; i++) cycle("md_mflo_d", 1);
    cycle("md_mflo_d_go", 0);
    chk("md_div_idle", md_busy, 0);

    // E priority: lw $8 then ori $8, jr $8 decided by E only
    do_reset("pri");
    d_set(8, TNEW_LOAD, 0, 0, TUSE_ALU, 1'b0, 1'b0, 1'b0);
    cycle("pri_lw", 0);
    d_set(8, TNEW_ALU, 0, 0, TUSE_ALU, 1'b0, 1'b0, 1'b0);
    cycle("pri_ori", 0);
    d_set(0, 0, 8, 0, TUSE_BRANCH, 1'b0, 1'b0, 1'b0);
    cycle("pri_jr1", 1);
    cycle("pri_jr2", 0);

    // back-to-back divs saturate the 4-bit stall counter
    d_set(0, 0, 0, 0, TUSE_ALU, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 24; i++) cycle("sat", -1);
    chk("sat_cnt", stall_cnt, 15);

    // reset three cycles into a div
    d_clear();
    for (int i = 0; i < DL + 1; i++) cycle("rd_drain", 0);
    d_set(0, 0, 0, 0, TUSE_ALU, 1'b0, 1'b1, 1'b0);
    cycle("rd_div", 0);
    d_set(4, TNEW_ALU, 1, 2, TUSE_ALU, 1'b0, 1'b0, 1'b0);
    cycle("rd_add4", 0);
    d_set(5, TNEW_ALU, 1, 2, TUSE_ALU, 1'b0, 1'b0, 1'b0);
    cycle("rd_add5", 0);
    chk("rd_busy_pre", md_busy, 1);
    chk("rd_a3E_pre", a3_E, 5);
    chk("rd_cnt_pre", stall_cnt, 15);
    d_set(6, TNEW_ALU, 5, 4, TUSE_BRANCH, 1'b0, 1'b0, 1'b1);
    do_reset("rd");

    // random D stream
    for (int i = 0; i < 400; i++) begin
      we_D      = 1'($urandom_range(0, 1));
      a3_D      = RAW'($urandom_range(0, 3));
      tnew_D    = TW'($urandom_range(0, 3));
      rs_D      = RAW'($urandom_range(0, 3));
      rt_D      = RAW'($urandom_range(0, 3));
      rs_use_D  = 1'($urandom_range(0, 1));
      rt_use_D  = 1'($urandom_range(0, 1));
      rs_tuse_D = TW'($urandom_range(TUSE_BRANCH, TUSE_STORE));
      rt_tuse_D = TW'($urandom_range(TUSE_BRANCH, TUSE_STORE));
      mult_D    = ($urandom_range(0, 7) == 0);
      div_D     = ($urandom_range(0, 7) == 0);
      md_use_D  = ($urandom_range(0, 3) == 0);
      cycle("rnd", -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
